// File: rtl/drip_zone_controller.sv
// Multi-zone drip irrigation sequencer: opens one zone valve at a time,
// granting dry zones round-robin, with bounded burst length and pump cooldown.
module drip_zone_controller #(
  parameter int ZONES    = 4,
  parameter int MIN_ON   = 8,
  parameter int MAX_ON   = 64,
  parameter int COOLDOWN = 16,
  parameter int CNT_W    = 8,
  localparam int ZW      = (ZONES > 1) ? $clog2(ZONES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ZONES-1:0] soil_dry,
  input  logic             air_humidity,
  input  logic             low_temperature,
  input  logic             mid_water_level,
  input  logic             tank_empty,
  input  logic             timeout_clr,
  output logic [ZONES-1:0] valve,
  output logic [ZW-1:0]    active_zone,
  output logic             busy,
  output logic [ZONES-1:0] zone_timeout
);

  if (ZONES < 2) begin : g_bad_zones
    $error("ZONES must be at least 2");
  end
  if (MAX_ON < 1 || COOLDOWN < 1) begin : g_bad_times
    $error("MAX_ON and COOLDOWN must be at least 1");
  end
  if (MIN_ON > MAX_ON) begin : g_bad_min
    $error("MIN_ON must not exceed MAX_ON");
  end
  if (CNT_W < 1 || CNT_W > 30 || MAX_ON >= (2 ** CNT_W) || COOLDOWN >= (2 ** CNT_W)) begin : g_bad_cnt
    $error("CNT_W too small for MAX_ON / COOLDOWN");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRIP = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ZW-1:0]    rr;

  logic             wx_ok;
  logic [ZONES-1:0] dem;
  logic             any_dem;
  logic [ZW-1:0]    grant;
  logic [ZW-1:0]    grant_hi;
  logic             hit_hi;
  logic [ZONES-1:0] grant_oh;
  logic [ZONES-1:0] to_set;
  logic [ZW-1:0]    rr_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             abort;
  logic             hit_max;
  logic             min_ok;
  logic             dem_g;

  // Humid air is only acceptable when cold, or when the tank is below mid level.
  assign wx_ok = air_humidity & (low_temperature | ~mid_water_level);

  for (genvar gi = 0; gi < ZONES; gi++) begin : g_zone
    assign dem[gi]      = enable & ~tank_empty & wx_ok & soil_dry[gi];
    assign grant_oh[gi] = (grant == ZW'(gi));
    assign to_set[gi]   = (state == DRIP) & ~abort & hit_max & (active_zone == ZW'(gi));
  end

  assign any_dem = |dem;

  // Lowest demanding zone at/above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    grant    = '0;
    grant_hi = '0;
    hit_hi   = 1'b0;
    for (int i = ZONES - 1; i >= 0; i--) begin
      if (dem[i]) begin
        grant = ZW'(i);
        if (ZW'(i) >= rr) begin
          grant_hi = ZW'(i);
          hit_hi   = 1'b1;
        end
      end
    end
    if (hit_hi) begin
      grant = grant_hi;
    end
  end

  assign rr_next = (grant == ZW'(ZONES - 1)) ? '0 : grant + 1'b1;
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign abort   = tank_empty | ~enable;
  assign hit_max = (cnt == CNT_W'(MAX_ON));
  assign min_ok  = (cnt >= CNT_W'(MIN_ON));
  assign dem_g   = dem[active_zone];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      valve        <= '0;
      active_zone  <= '0;
      busy         <= 1'b0;
      zone_timeout <= '0;
      rr           <= '0;
      cnt          <= '0;
    end else begin
      // A timeout being set in the same cycle as a clear request survives.
      zone_timeout <= (timeout_clr ? '0 : zone_timeout) | to_set;
      case (state)
        IDLE: begin
          if (any_dem) begin
            state       <= DRIP;
            valve       <= grant_oh;
            active_zone <= grant;
            busy        <= 1'b1;
            cnt         <= CNT_W'(1);
            rr          <= rr_next;
          end
        end
        DRIP: begin
          if (abort || hit_max || (min_ok && !dem_g)) begin
            state <= COOL;
            valve <= '0;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        COOL: begin
          if (cnt == CNT_W'(COOLDOWN - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          valve <= '0;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drip_zone_controller.sv
// Directed bench for drip_zone_controller: a per-cycle vector table plus
// hand-written sequences for long bursts, round-robin, interlock and reset.
module tb_drip_zone_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] soil_dry;
  logic       air_humidity;
  logic       low_temperature;
  logic       mid_water_level;
  logic       tank_empty;
  logic       timeout_clr;
  logic [3:0] valve;
  logic [1:0] active_zone;
  logic       busy;
  logic [3:0] zone_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  drip_zone_controller #(
    .ZONES(4), .MIN_ON(8), .MAX_ON(64), .COOLDOWN(16), .CNT_W(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .soil_dry       (soil_dry),
    .air_humidity   (air_humidity),
    .low_temperature(low_temperature),
    .mid_water_level(mid_water_level),
    .tank_empty     (tank_empty),
    .timeout_clr    (timeout_clr),
    .valve          (valve),
    .active_zone    (active_zone),
    .busy           (busy),
    .zone_timeout   (zone_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [3:0] soil;
    logic       air;
    logic       lowt;
    logic       mid;
    logic       tank;
    logic       clr;
    logic [3:0] ev;
    logic [1:0] ez;
    logic       eb;
    logic [3:0] et;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [3:0] soil, input logic air, input logic lowt,
                     input logic mid, input logic tank, input logic clr,
                     input logic [3:0] ev, input logic [1:0] ez, input logic eb, input logic [3:0] et);
    vec_t v;
    v.en = en; v.soil = soil; v.air = air; v.lowt = lowt; v.mid = mid;
    v.tank = tank; v.clr = clr; v.ev = ev; v.ez = ez; v.eb = eb; v.et = et;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_defaults();
    enable          = 1'b1;
    soil_dry        = 4'b0000;
    air_humidity    = 1'b1;
    low_temperature = 1'b1;
    mid_water_level = 1'b1;
    tank_empty      = 1'b0;
    timeout_clr     = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    set_defaults();
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_rst_valve"}, 32'(valve), 0);
    chk({tag, "_rst_zone"}, 32'(active_zone), 0);
    chk({tag, "_rst_busy"}, 32'(busy), 0);
    chk({tag, "_rst_timeout"}, 32'(zone_timeout), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi, off, bsy, w, bad;
    int order[4];
    order[0] = 0; order[1] = 1; order[2] = 3; order[3] = 0;

    rst_n = 1'b0;
    set_defaults();

    // Weather gate, MIN_ON hold after early demand loss, COOL length, rr and enable abort.
    add(1, 4'b0010, 1, 0, 1, 0, 0, 4'b0000, 2'd0, 0, 4'b0000);
    add(1, 4'b0010, 1, 0, 1, 0, 0, 4'b0000, 2'd0, 0, 4'b0000);
    add(1, 4'b0010, 1, 0, 0, 0, 0, 4'b0010, 2'd1, 1, 4'b0000);
    add(1, 4'b0010, 1, 0, 0, 0, 0, 4'b0010, 2'd1, 1, 4'b0000);
    add(1, 4'b0010, 1, 0, 0, 0, 0, 4'b0010, 2'd1, 1, 4'b0000);
    for (int k = 0; k < 5; k++) add(1, 4'b0000, 1, 0, 0, 0, 0, 4'b0010, 2'd1, 1, 4'b0000);
    add(1, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 2'd1, 1, 4'b0000);
    for (int k = 0; k < 15; k++) add(1, 4'b1000, 1, 0, 0, 0, 0, 4'b0000, 2'd1, 1, 4'b0000);
    add(1, 4'b1000, 1, 0, 0, 0, 0, 4'b0000, 2'd1, 0, 4'b0000);
    add(1, 4'b1000, 1, 0, 0, 0, 0, 4'b1000, 2'd3, 1, 4'b0000);
    add(0, 4'b1000, 1, 0, 0, 0, 0, 4'b0000, 2'd3, 1, 4'b0000);
    add(0, 4'b1000, 1, 0, 0, 0, 0, 4'b0000, 2'd3, 1, 4'b0000);

    do_reset("tbl");
    foreach (vecs[i]) begin
      enable          = vecs[i].en;
      soil_dry        = vecs[i].soil;
      air_humidity    = vecs[i].air;
      low_temperature = vecs[i].lowt;
      mid_water_level = vecs[i].mid;
      tank_empty      = vecs[i].tank;
      timeout_clr     = vecs[i].clr;
      step();
      $display("vec %0d: valve=%b zone=%0d busy=%b timeout=%b", i, valve, active_zone, busy, zone_timeout);
      chk($sformatf("vec%0d_valve", i), 32'(valve), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_zone", i), 32'(active_zone), 32'(vecs[i].ez));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].eb));
      chk($sformatf("vec%0d_timeout", i), 32'(zone_timeout), 32'(vecs[i].et));
    end

    // Held demand: MAX_ON-long burst, timeout flag, cooldown, clear, re-grant, set-dominant clear.
    do_reset("t1");
    soil_dry = 4'b0100;
    step();
    chk("t1_grant_valve", 32'(valve), 32'h4);
    chk("t1_grant_zone", 32'(active_zone), 2);
    hi = 1;
    for (int k = 0; k < 200; k++) begin
      step();
      if (valve == 4'b0100) hi++;
      else break;
    end
    chk("t1_on_cycles", hi, 64);
    chk("t1_timeout_set", 32'(zone_timeout), 32'h4);
    chk("t1_busy_cool", 32'(busy), 1);
    off = 1; bsy = 1;
    for (int k = 0; k < 100; k++) begin
      timeout_clr = (off == 2);
      step();
      if (valve != 4'b0000) break;
      off++;
      if (busy) bsy++;
    end
    timeout_clr = 1'b0;
    chk("t1_off_cycles", off, 17);
    chk("t1_cool_busy_cycles", bsy, 16);
    chk("t1_timeout_cleared", 32'(zone_timeout), 0);
    chk("t1_regrant_valve", 32'(valve), 32'h4);
    chk("t1_regrant_zone", 32'(active_zone), 2);
    hi = 1;
    for (int k = 0; k < 200; k++) begin
      timeout_clr = (hi == 64);
      step();
      if (valve == 4'b0100) hi++;
      else break;
    end
    timeout_clr = 1'b0;
    chk("t1_on_cycles_2", hi, 64);
    chk("t1_set_beats_clr", 32'(zone_timeout), 32'h4);
    $display("t1 done: second burst %0d cycles, timeout=%b", hi, zone_timeout);

    // Round-robin over zones 0,1,3 with zone 2 idle.
    do_reset("t2");
    soil_dry = 4'b1011;
    for (int n = 0; n < 4; n++) begin
      w = 0;
      while (valve == 4'b0000 && w < 40) begin
        step();
        w++;
      end
      chk($sformatf("t2_wait%0d", n), int'(w < 40), 1);
      chk($sformatf("t2_valve%0d", n), 32'(valve), 1 << order[n]);
      chk($sformatf("t2_zone%0d", n), 32'(active_zone), order[n]);
      $display("t2 grant %0d: zone=%0d", n, active_zone);
      w = 0;
      while (valve != 4'b0000 && w < 100) begin
        step();
        w++;
      end
      chk($sformatf("t2_burst%0d", n), w, 64);
    end
    chk("t2_timeouts", 32'(zone_timeout), 32'hB);

    // Tank interlock abort at cnt=3, no re-grant while empty.
    do_reset("t4");
    soil_dry = 4'b0001;
    step();
    chk("t4_grant", 32'(valve), 32'h1);
    step();
    step();
    tank_empty = 1'b1;
    step();
    chk("t4_abort_valve", 32'(valve), 0);
    chk("t4_abort_busy", 32'(busy), 1);
    bad = 0; bsy = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (valve != 4'b0000) bad++;
      if (busy) bsy++;
    end
    chk("t4_no_regrant", bad, 0);
    chk("t4_cool_busy", bsy, 15);
    chk("t4_no_timeout", 32'(zone_timeout), 0);
    tank_empty = 1'b0;
    step();
    chk("t4_refill_grant", 32'(valve), 32'h1);
    $display("t4 done: valve=%b after refill", valve);

    // Asynchronous reset mid-burst, then rr pointer restarts at zone 0.
    do_reset("t5");
    soil_dry = 4'b0010;
    step();
    for (int k = 0; k < 19; k++) step();
    chk("t5_mid_drip", 32'(valve), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valve", 32'(valve), 0);
    chk("t5_async_busy", 32'(busy), 0);
    chk("t5_async_zone", 32'(active_zone), 0);
    @(negedge clk);
    soil_dry = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t5_restart_valve", 32'(valve), 32'h1);
    chk("t5_restart_zone", 32'(active_zone), 0);
    $display("t5 done: first grant after reset zone=%0d", active_zone);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
